// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// A single full-adder slice with b inverted and carry preset to 1; start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic nb, s, carry_next;

  // Full-adder slice on the current LSBs.
  always_comb begin
    nb         = ~b_sh_q[0];
    s          = a_sh_q[0] ^ nb ^ carry_q;
    carry_next = (a_sh_q[0] & nb) | (carry_q & (a_sh_q[0] ^ nb));
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    count_d    = count_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          acc_d   = '0;
          carry_d = 1'b1;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = {s, acc_q[WIDTH-1:1]};
        carry_d = carry_next;
        count_d = count_q + 1'b1;
        // Outputs are published only here so partial results never show.
        if (count_q == LAST) begin
          diff_d     = {s, acc_q[WIDTH-1:1]};
          borrow_d   = ~carry_next;
          overflow_d = carry_q ^ carry_next;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random 8-bit cases plus exhaustive back-to-back 4-bit sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, borrow8, overflow8;
  logic [7:0] diff8;
  logic       busy4, done4, borrow4, overflow4;
  logic [3:0] diff4;

  int n_assert = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(overflow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
  function automatic void model(input int w, input int ua, input int ub,
                                output int d, output int bo, output int ov);
    int m, sa, sb, r;
    m  = 1 << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sa - sb;
    d  = (ua - ub + m) % m;
    bo = (ua < ub) ? 1 : 0;
    ov = (r > m / 2 - 1 || r < -(m / 2)) ? 1 : 0;
  endfunction

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                         input logic eb, input logic eo, input string tag);
    start8 = 1'b1; a8 = av; b8 = bv;
    tick();
    start8 = 1'b0; a8 = 'x; b8 = 'x;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, 32'(busy8), 32'd1);
      check({tag, "_early_done"}, 32'(done8), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
    check({tag, "_diff"}, 32'(diff8), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow8), 32'(eb));
    check({tag, "_overflow"}, 32'(overflow8), 32'(eo));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
    check({tag, "_diff_held"}, 32'(diff8), 32'(ed));
  endtask

  initial begin
    int d, bo, ov;
    int ua, ub;

    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
    check("rst_overflow", 32'(overflow8), 32'd0);

    run_op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "basic");
    run_op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "borrow");
    run_op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "ovf_neg");
    run_op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "ovf_pos");
    run_op8(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, "equal");
    run_op8(8'hC3, 8'h00, 8'hC3, 1'b0, 1'b0, "b_zero");

    for (int k = 0; k < 24; k++) begin
      ua = int'($urandom_range(255));
      ub = int'($urandom_range(255));
      model(8, ua, ub, d, bo, ov);
      run_op8(8'(ua), 8'(ub), 8'(d), 1'(bo), 1'(ov), "rand");
    end

    // Start while busy: second pulse in RUN cycle 3 must be ignored.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("busy_start_done", 32'(done8), 32'd1);
    check("busy_start_diff", 32'(diff8), 32'h0F);
    check("busy_start_borrow", 32'(borrow8), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("busy_start_no_second_done", 32'(done8), 32'd0);
    end

    // Reset during RUN cycle 4.
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h01;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_diff", 32'(diff8), 32'd0);
    check("midrst_borrow", 32'(borrow8), 32'd0);
    check("midrst_overflow", 32'(overflow8), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("midrst_no_done", 32'(done8), 32'd0);
    end
    run_op8(8'h09, 8'h09, 8'h00, 1'b0, 1'b0, "after_rst");

    // Exhaustive 4-bit sweep, start asserted in every DONE cycle.
    for (int idx = 0; idx < 256; idx++) begin
      ua = idx / 16;
      ub = idx % 16;
      start4 = 1'b1; a4 = 4'(ua); b4 = 4'(ub);
      tick();
      start4 = 1'b0; a4 = 'x; b4 = 'x;
      check("w4_busy_immediate", 32'(busy4), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      check("w4_busy_last", 32'(busy4), 32'd1);
      tick();
      model(4, ua, ub, d, bo, ov);
      check("w4_done", 32'(done4), 32'd1);
      check("w4_diff", 32'(diff4), 32'(d));
      check("w4_borrow", 32'(borrow4), 32'(bo));
      check("w4_overflow", 32'(overflow4), 32'(ov));
    end
    tick();
    check("w4_idle_after", 32'(done4), 32'd0);
    check("w4_busy_after", 32'(busy4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
